// File: rtl/approx_mult_err_scanner.sv
// Exhaustive error scanner for an external approximate N x N multiplier.
// Sweeps every (a, b) pair, compares the returned product against the exact
// product and accumulates correct/error counts, summed and maximum error distance.
module approx_mult_err_scanner #(
  parameter int N   = 8,
  parameter int LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N-1:0]     a_o,
  output logic [N-1:0]     b_o,
  input  logic [2*N-1:0]   y_i,
  output logic             busy,
  output logic             done,
  output logic [2*N:0]     correct_cnt,
  output logic [2*N:0]     err_cnt,
  output logic [4*N-1:0]   sum_ed,
  output logic [2*N-1:0]   max_ed
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             clear;
  logic             flush;
  logic [2*N-1:0]   idx_q, idx_d;

  // Pair currently presented to the external multiplier
  logic             pres_v;
  logic             pres_last;

  // Pair whose product is on y_i this cycle (after LAT stages)
  logic             tap_v;
  logic             tap_last;
  logic [2*N-1:0]   tap_ab;

  // Capture stage: product plus the operands it belongs to
  logic             cap_v_q;
  logic             cap_last_q;
  logic [2*N-1:0]   cap_ab_q;
  logic [2*N-1:0]   cap_y_q;

  logic [2*N-1:0]   exact;
  logic [2*N-1:0]   ed;
  logic             upd;

  logic [2*N:0]     correct_q, correct_d;
  logic [2*N:0]     err_q, err_d;
  logic [4*N-1:0]   sum_q, sum_d;
  logic [2*N-1:0]   max_q, max_d;

  assign pres_v    = (state_q == S_RUN);
  assign pres_last = pres_v && (idx_q == '1);
  assign a_o       = pres_v ? idx_q[2*N-1:N] : '0;
  assign b_o       = pres_v ? idx_q[N-1:0]   : '0;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign flush     = abort && busy;

  // Next-state logic; abort wins over normal progress while busy
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          clear   = 1'b1;
        end
      end
      S_RUN: begin
        if (abort)              state_d = S_IDLE;
        else if (idx_q == '1)   state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                       state_d = S_IDLE;
        else if (cap_v_q && cap_last_q)  state_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          clear   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and pair index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Pair index: cleared on start, advances once per RUN cycle
  always_comb begin
    idx_d = idx_q;
    if (clear)       idx_d = '0;
    else if (pres_v) idx_d = idx_q + 1'b1;
  end

  // Operand delay line matching the external multiplier latency
  generate
    if (LAT == 0) begin : g_nodl
      assign tap_v    = pres_v;
      assign tap_last = pres_last;
      assign tap_ab   = pres_v ? idx_q : '0;
    end else begin : g_dl
      logic           dl_v_q    [LAT];
      logic           dl_last_q [LAT];
      logic [2*N-1:0] dl_ab_q   [LAT];

      // Shift presented pairs down the line; abort drops everything in flight
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < LAT; i++) begin
            dl_v_q[i]    <= 1'b0;
            dl_last_q[i] <= 1'b0;
            dl_ab_q[i]   <= '0;
          end
        end else begin
          dl_v_q[0]    <= pres_v && !flush;
          dl_last_q[0] <= pres_last;
          dl_ab_q[0]   <= idx_q;
          for (int unsigned i = 1; i < LAT; i++) begin
            dl_v_q[i]    <= dl_v_q[i-1] && !flush;
            dl_last_q[i] <= dl_last_q[i-1];
            dl_ab_q[i]   <= dl_ab_q[i-1];
          end
        end
      end

      assign tap_v    = dl_v_q[LAT-1];
      assign tap_last = dl_last_q[LAT-1];
      assign tap_ab   = dl_ab_q[LAT-1];
    end
  endgenerate

  // Capture the returned product together with its operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_v_q    <= 1'b0;
      cap_last_q <= 1'b0;
      cap_ab_q   <= '0;
      cap_y_q    <= '0;
    end else begin
      cap_v_q    <= tap_v && !flush;
      cap_last_q <= tap_last;
      cap_ab_q   <= tap_ab;
      cap_y_q    <= y_i;
    end
  end

  // Exact product and error distance of the captured pair
  always_comb begin
    exact = {{N{1'b0}}, cap_ab_q[2*N-1:N]} * {{N{1'b0}}, cap_ab_q[N-1:0]};
    ed    = (cap_y_q >= exact) ? (cap_y_q - exact) : (exact - cap_y_q);
    upd   = cap_v_q && !flush;
  end

  // Statistics next-state: cleared on start, accumulate on each captured pair
  always_comb begin
    correct_d = correct_q;
    err_d     = err_q;
    sum_d     = sum_q;
    max_d     = max_q;
    if (clear) begin
      correct_d = '0;
      err_d     = '0;
      sum_d     = '0;
      max_d     = '0;
    end else if (upd) begin
      if (ed == '0) begin
        correct_d = correct_q + (2*N+1)'(1);
      end else begin
        err_d = err_q + (2*N+1)'(1);
        sum_d = sum_q + {{(2*N){1'b0}}, ed};
        if (ed > max_q) max_d = ed;
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      correct_q <= '0;
      err_q     <= '0;
      sum_q     <= '0;
      max_q     <= '0;
    end else begin
      correct_q <= correct_d;
      err_q     <= err_d;
      sum_q     <= sum_d;
      max_q     <= max_d;
    end
  end

  assign correct_cnt = correct_q;
  assign err_cnt     = err_q;
  assign sum_ed      = sum_q;
  assign max_ed      = max_q;

endmodule

// File: doc/approx_mult_err_scanner.md
APPROX_MULT_ERR_SCANNER -- requirements
Module: approx_mult_err_scanner

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits of the multiplier under test (2..12).
REQ-002 SHALL have parameter LAT, default 0, cycles from a_o/b_o presentation to valid y_i (0 = combinational DUT).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin exhaustive sweep; sampled only in IDLE or DONE.
REQ-006 SHALL have port abort  input  1  cancel sweep in progress.
REQ-007 SHALL have port a_o  output  N  operand A driven to external multiplier.
REQ-008 SHALL have port b_o  output  N  operand B driven to external multiplier.
REQ-009 SHALL have port y_i  input  2N  product returned by external multiplier.
REQ-010 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-011 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-012 SHALL have port correct_cnt  output  2N+1  pairs with y_i equal to exact product.
REQ-013 SHALL have port err_cnt  output  2N+1  pairs with y_i not equal to exact product.
REQ-014 SHALL have port sum_ed  output  4N  sum of error distances |y_i - a*b|.
REQ-015 SHALL have port max_ed  output  2N  largest error distance seen.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN after last pair presented; DRAIN->DONE when last result accumulated; DONE->IDLE next cycle, or DONE->RUN if start high.
REQ-017 SHALL on the edge sampling start (edge 0) clear all four statistics outputs and the pair index.
REQ-018 SHALL present pair k (k = 0..2^(2N)-1) during the cycle after edge k; a_o = k[2N-1:N], b_o = k[N-1:0] (b increments fastest, a outer).
REQ-019 SHALL capture y_i with a delayed copy of the matching a/b (LAT-deep delay line) at edge k+LAT+1.
REQ-020 SHALL compute exact product internally as full 2N-bit unsigned a*b; ED = |y_i - exact| in 2N bits, unsigned.
REQ-021 SHALL update statistics for pair k at edge k+LAT+2: ED==0 increments correct_cnt, else increments err_cnt, adds ED to sum_ed, and sets max_ed = max(max_ed, ED).
REQ-022 SHALL assert done for exactly one cycle following edge 2^(2N)+LAT+1, with all statistics final in that cycle; busy drops the same cycle.
REQ-023 SHALL hold a_o/b_o at zero outside RUN.
REQ-024 SHALL hold statistics stable after completion or abort until next accepted start.
REQ-025 SHALL ignore start while busy.
REQ-026 SHALL on abort high in RUN or DRAIN go to IDLE at that edge, discard in-flight pipeline results, not pulse done, and retain partial statistics.
REQ-027 SHALL give abort no effect in IDLE or DONE; start and abort high together in IDLE SHALL start the sweep.
REQ-028 SHALL guarantee correct_cnt + err_cnt == 2^(2N) at done; counters never wrap (widths sized accordingly).

Reset
REQ-029 SHALL on rst_n low, at any time including mid-sweep, immediately force IDLE, clear delay line, and drive busy=0, done=0, a_o=b_o=0, correct_cnt=err_cnt=sum_ed=max_ed=0.
REQ-030 SHALL require a fresh start after rst_n release; no sweep resumes.

Verification
REQ-031 SHALL test N=8, LAT=0, exact DUT: start -> done after 65538 edges; correct_cnt=65536, err_cnt=0, sum_ed=0, max_ed=0.
REQ-032 SHALL test N=8, LAT=0, DUT y=(a*b) with bit0 forced 0: err_cnt=16384, correct_cnt=49152, sum_ed=16384, max_ed=1.
REQ-033 SHALL test N=2, LAT=2, DUT registered 2 stages outputting 0: done after edge 19; err_cnt=9, correct_cnt=7, sum_ed=36, max_ed=9.
REQ-034 SHALL test abort at pair 100 (N=8): busy->0 next cycle, no done, statistics frozen, subsequent start gives full REQ-031 results.
REQ-035 SHALL test rst_n pulsed low mid-sweep: all outputs 0 asynchronously, state IDLE; start pulses during busy produce no restart or count change.
